mdr_arith_core: RTL and testbench

// - Arithmetic back end of the MDR. Sits directly downstream of the operand-load control FSM.
// - Captures two operands from the shared data bus on that FSM's per-channel load enables.
// - On the FSM's start flag, runs an iterative multiply, divide or square root.
// - Returns a one-cycle ready pulse that sends the FSM back to IDLE.

---
 rtl/mdr_arith_core.sv | 169 ++++++++++++++++
 tb/tb_mdr_arith_core.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mdr_arith_core.sv
// MDR arithmetic back end: iterative unsigned multiply, divide and optional square root.
// Build option: MDR_SQRT_EN enables the square-root datapath for op_sel=10.
module mdr_arith_core #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               load_op1,
  input  logic               load_op2,
  input  logic               start,
  input  logic [1:0]         op_sel,
  output logic [2*WIDTH-1:0] result,
  output logic [WIDTH-1:0]   remainder,
  output logic               ready,
  output logic               busy,
  output logic               error
);

  localparam int HW = WIDTH / 2;
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_SQRT = 2'b10;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic               start_q;
  logic [WIDTH-1:0]   op1, op2;
  logic [1:0]         wop;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt, last;

  logic trig, sqrt_ok, div_zero, bad;

`ifdef MDR_SQRT_EN
  assign sqrt_ok = 1'b1;
`else
  assign sqrt_ok = 1'b0;
`endif

  assign trig     = start & ~start_q;
  assign div_zero = (op_sel == OP_DIV) && (op2 == '0);
  assign bad      = div_zero || (op_sel == 2'b11) ||
                    ((op_sel == OP_SQRT) && !sqrt_ok);

  // Shift-add multiplier: product high half in acc[2W-1:W], multiplier shifts out of acc[0]
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx;
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} +
                   (acc[0] ? {1'b0, opnd} : '0);
  assign mul_nx  = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divider: partial remainder high, dividend/quotient low
  logic [WIDTH:0]     div_sh;
  logic [WIDTH-1:0]   div_diff, div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_nx;
  assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign div_ge   = div_sh >= {1'b0, opnd};
  assign div_diff = div_sh[WIDTH-1:0] - opnd;
  assign div_rem  = div_ge ? div_diff : div_sh[WIDTH-1:0];
  assign div_nx   = {div_rem, acc[WIDTH-2:0], div_ge};

`ifdef MDR_SQRT_EN
  logic [WIDTH-1:0] sq_rad;
  logic [HW-1:0]    sq_root, sq_root_nx;
  logic [HW:0]      sq_rem, sq_diff, sq_rem_nx;
  logic [HW+1:0]    sq_sh, sq_trial;
  logic             sq_ge;
  assign sq_sh      = {sq_rem[HW-1:0], sq_rad[WIDTH-1:WIDTH-2]};
  assign sq_trial   = {sq_root, 2'b01};
  assign sq_ge      = sq_sh >= sq_trial;
  assign sq_diff    = sq_sh[HW:0] - sq_trial[HW:0];
  assign sq_rem_nx  = sq_ge ? sq_diff : sq_sh[HW:0];
  assign sq_root_nx = {sq_root[HW-2:0], sq_ge};
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (trig) state_d = bad ? DONE : RUN;
      RUN:     if (cnt == last) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == RUN);
  assign ready = (state_q == DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      start_q   <= 1'b0;
      op1       <= '0;
      op2       <= '0;
      wop       <= '0;
      opnd      <= '0;
      acc       <= '0;
      cnt       <= '0;
      last      <= '0;
      result    <= '0;
      remainder <= '0;
      error     <= 1'b0;
`ifdef MDR_SQRT_EN
      sq_rad    <= '0;
      sq_root   <= '0;
      sq_rem    <= '0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start;
      if (load_op1) op1 <= data_in;
      if (load_op2) op2 <= data_in;
      case (state_q)
        IDLE: if (trig) begin
          cnt  <= '0;
          wop  <= op_sel;
          opnd <= op2;
          acc  <= {{WIDTH{1'b0}}, op1};
          last <= (op_sel == OP_SQRT) ? CW'(HW - 1) : CW'(WIDTH - 1);
`ifdef MDR_SQRT_EN
          sq_rad  <= op1;
          sq_root <= '0;
          sq_rem  <= '0;
`endif
          if (bad) begin
            error     <= 1'b1;
            result    <= div_zero ? {{WIDTH{1'b0}}, {WIDTH{1'b1}}} : '0;
            remainder <= div_zero ? op1 : '0;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          acc <= (wop == OP_DIV) ? div_nx : mul_nx;
`ifdef MDR_SQRT_EN
          sq_rad  <= sq_rad << 2;
          sq_root <= sq_root_nx;
          sq_rem  <= sq_rem_nx;
`endif
          if (cnt == last) begin
            error <= 1'b0;
            unique case (1'b1)
              (wop == OP_DIV): begin
                result    <= {{WIDTH{1'b0}}, div_nx[WIDTH-1:0]};
                remainder <= div_rem;
              end
`ifdef MDR_SQRT_EN
              (wop == OP_SQRT): begin
                result    <= {{(2*WIDTH-HW){1'b0}}, sq_root_nx};
                remainder <= {{(WIDTH-HW-1){1'b0}}, sq_rem_nx};
              end
`endif
              default: begin
                result    <= mul_nx;
                remainder <= '0;
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdr_arith_core.sv
// Directed self-checking bench for mdr_arith_core at WIDTH=16.
module tb_mdr_arith_core;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [W-1:0]   data_in = '0;
  logic           load_op1 = 1'b0;
  logic           load_op2 = 1'b0;
  logic           start = 1'b0;
  logic [1:0]     op_sel = 2'b00;
  logic [2*W-1:0] result;
  logic [W-1:0]   remainder;
  logic           ready, busy, error;

  int checks = 0;
  int errors = 0;
  int lat, nbusy, nrdy;

  mdr_arith_core #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .data_in(data_in),
    .load_op1(load_op1), .load_op2(load_op2),
    .start(start), .op_sel(op_sel),
    .result(result), .remainder(remainder),
    .ready(ready), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    data_in = a; load_op1 = 1'b1;
    @(negedge clk);
    load_op1 = 1'b0; data_in = b; load_op2 = 1'b1;
    @(negedge clk);
    load_op2 = 1'b0;
  endtask

  // lat counts edges from the trigger edge (inclusive) to the first ready sample
  task automatic run_op(input logic [1:0] sel, output int l,
                        output int nb, output int nr);
    l = -1; nb = 0; nr = 0;
    @(negedge clk);
    op_sel = sel; start = 1'b1;
    for (int e = 1; e <= 40; e++) begin
      @(posedge clk); #1;
      if (busy) nb++;
      if (ready) begin
        if (nr == 0) l = e;
        nr++;
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_result", result, 0);
    chk("rst_rem", remainder, 0);
    chk("rst_ready", ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    @(negedge clk);
    reset = 1'b1;

    load(16'd300, 16'd200);
    run_op(2'b00, lat, nbusy, nrdy);
    chk("mul_lat", lat, 17);
    chk("mul_busy", nbusy, 16);
    chk("mul_nrdy", nrdy, 1);
    chk("mul_result", result, 60000);
    chk("mul_rem", remainder, 0);
    chk("mul_error", error, 0);

    load(16'hFFFF, 16'hFFFF);
    run_op(2'b00, lat, nbusy, nrdy);
    chk("mul_max", result, 32'hFFFE_0001);

    load(16'd1000, 16'd7);
    run_op(2'b01, lat, nbusy, nrdy);
    chk("div_result", result, 142);
    chk("div_rem", remainder, 6);
    chk("div_lat", lat, 17);
    chk("div_nrdy", nrdy, 1);

    load(16'd1234, 16'd0);
    run_op(2'b01, lat, nbusy, nrdy);
    chk("dz_lat", lat, 1);
    chk("dz_busy", nbusy, 0);
    chk("dz_error", error, 1);
    chk("dz_result", result, 32'h0000_FFFF);
    chk("dz_rem", remainder, 1234);

    load(16'd10, 16'd3);
    run_op(2'b01, lat, nbusy, nrdy);
    chk("div3_result", result, 3);
    chk("div3_rem", remainder, 1);
    chk("div3_error", error, 0);

    load(16'd1000, 16'd5);
    run_op(2'b10, lat, nbusy, nrdy);
`ifdef MDR_SQRT_EN
    chk("sqrt_lat", lat, 9);
    chk("sqrt_busy", nbusy, 8);
    chk("sqrt_result", result, 31);
    chk("sqrt_rem", remainder, 39);
    chk("sqrt_error", error, 0);
`else
    chk("sqrt_lat", lat, 1);
    chk("sqrt_error", error, 1);
    chk("sqrt_result", result, 0);
`endif

    load(16'd77, 16'd5);
    run_op(2'b11, lat, nbusy, nrdy);
    chk("rsv_lat", lat, 1);
    chk("rsv_error", error, 1);
    chk("rsv_result", result, 0);
    chk("rsv_rem", remainder, 0);

    @(negedge clk);
    data_in = 16'd9; load_op1 = 1'b1; load_op2 = 1'b1;
    @(negedge clk);
    load_op1 = 1'b0; load_op2 = 1'b0; data_in = 16'd4;
    run_op(2'b00, lat, nbusy, nrdy);
    chk("both_result", result, 81);
    chk("both_error", error, 0);

    load(16'd5, 16'd0);
    run_op(2'b01, lat, nbusy, nrdy);
    chk("dz2_error", error, 1);
    load(16'd300, 16'd200);
    @(negedge clk);
    op_sel = 2'b00; start = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    chk("mid_busy_pre", busy, 1);
    reset = 1'b0;
    #1;
    chk("mid_result", result, 0);
    chk("mid_rem", remainder, 0);
    chk("mid_busy", busy, 0);
    chk("mid_ready", ready, 0);
    chk("mid_error", error, 0);
    @(negedge clk);
    start = 1'b0;
    nrdy = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ready) nrdy++;
    end
    chk("mid_no_ready", nrdy, 0);
    @(negedge clk);
    reset = 1'b1;

    load(16'd12, 16'd13);
    run_op(2'b00, lat, nbusy, nrdy);
    chk("post_lat", lat, 17);
    chk("post_result", result, 156);
    chk("post_nrdy", nrdy, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
